rojobot_wb_responder: RTL

CPU-side responder for the Rojobot update handshake. It synchronises `io_botupdt_sync` (a level from the 75 MHz bot domain) into `clk_core` and snapshots `io_botinfo` on each update. It raises an interrupt, and on software clear it drives the 4-phase `io_int_ack` back to the bot-side handshake flop. It exposes the snapshot, motor control and status as a Wishbone slave on the SweRVolf peripheral bus.

---
 rtl/rojobot_wb_pkg.sv | 21 ++
 rtl/bot_sync_edge.sv | 29 ++
 rtl/rojobot_wb_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rojobot_wb_pkg.sv
// Shared definitions for the Rojobot Wishbone responder: register map,
// STATUS bit positions and the ack handshake state type.
package rojobot_wb_pkg;

    localparam logic [2:0] REG_BOTINFO = 3'd0;
    localparam logic [2:0] REG_BOTCTRL = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_UPDCNT  = 3'd4;

    localparam int ST_PENDING  = 0;
    localparam int ST_ACK_BUSY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TIMEOUT  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACKING = 1'b1
    } ack_state_t;

endpackage

// File: rtl/bot_sync_edge.sv
// Multi-flop synchroniser for the bot-domain update level, followed by a
// history flop so a single-cycle rise pulse is produced in clk_core.
module bot_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic sync_q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_ff <= '0;
            hist_q  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
            hist_q  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];
    assign rise   = sync_q & ~hist_q;

endmodule

// File: rtl/rojobot_wb_responder.sv
// CPU-side responder for the Rojobot update handshake: snapshots bot info on
// each update, raises an interrupt and returns a 4-phase ack on software clear.
module rojobot_wb_responder
    import rojobot_wb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic [31:0] i_botinfo,
    input  logic        i_botupdt_sync,
    output logic [7:0]  o_botctrl,
    output logic        o_int_ack,
    output logic        o_irq
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic             sync_q;
    logic             rise;
    ack_state_t       state;
    logic [CNT_W-1:0] to_cnt;
    logic [31:0]      snap_q;
    logic [31:0]      updcnt_q;
    logic             pending_q;
    logic             overrun_q;
    logic             timeout_q;
    logic             ie_q;
    logic [31:0]      rd_data;

    bot_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (i_botupdt_sync),
        .sync_q   (sync_q),
        .rise     (rise)
    );

    // A request is accepted on the edge that raises o_wb_ack; writes land there too.
    logic       wb_req;
    logic       wr_en;
    logic [2:0] reg_sel;
    logic       st_wr;
    logic       clr_pend;
    logic       clr_ovr;
    logic       clr_to;
    logic       upd_wr;
    logic       ack_start;
    logic       timeout_hit;

    assign wb_req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr_en       = wb_req & i_wb_we;
    assign reg_sel     = i_wb_adr[4:2];
    assign st_wr       = wr_en & (reg_sel == REG_STATUS) & i_wb_sel[0];
    assign clr_pend    = st_wr & i_wb_dat[ST_PENDING];
    assign clr_ovr     = st_wr & i_wb_dat[ST_OVERRUN];
    assign clr_to      = st_wr & i_wb_dat[ST_TIMEOUT];
    assign upd_wr      = wr_en & (reg_sel == REG_UPDCNT);
    assign ack_start   = clr_pend & (state == IDLE);
    assign timeout_hit = (state == ACKING) & sync_q & (to_cnt == TO_LAST);

    logic unused_bits;
    assign unused_bits = ^{i_wb_adr[1:0], i_wb_dat[31:8], i_wb_dat[1], i_wb_sel[3:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            to_cnt    <= '0;
            o_int_ack <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ack_start) begin
                        state     <= ACKING;
                        to_cnt    <= '0;
                        o_int_ack <= 1'b1;
                    end
                end
                ACKING: begin
                    if (!sync_q || (to_cnt == TO_LAST)) begin
                        state     <= IDLE;
                        o_int_ack <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_int_ack <= 1'b0;
                end
            endcase
        end
    end

    // Hardware set events win over a same-cycle software clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_q    <= '0;
            updcnt_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            ie_q      <= 1'b0;
            o_botctrl <= '0;
        end else begin
            if (rise) begin
                snap_q    <= i_botinfo;
                updcnt_q  <= upd_wr ? 32'd1 : updcnt_q + 32'd1;
                pending_q <= 1'b1;
            end else begin
                if (upd_wr)   updcnt_q  <= '0;
                if (clr_pend) pending_q <= 1'b0;
            end
            if (rise && pending_q) overrun_q <= 1'b1;
            else if (clr_ovr)      overrun_q <= 1'b0;
            if (timeout_hit)       timeout_q <= 1'b1;
            else if (clr_to)       timeout_q <= 1'b0;
            if (wr_en && i_wb_sel[0] && (reg_sel == REG_BOTCTRL)) o_botctrl <= i_wb_dat[7:0];
            if (wr_en && i_wb_sel[0] && (reg_sel == REG_CTRL))    ie_q      <= i_wb_dat[0];
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_BOTINFO: rd_data = snap_q;
            REG_BOTCTRL: rd_data = {24'd0, o_botctrl};
            REG_STATUS:  rd_data = {28'd0, timeout_q, overrun_q, (state == ACKING), pending_q};
            REG_CTRL:    rd_data = {31'd0, ie_q};
            REG_UPDCNT:  rd_data = updcnt_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= wb_req;
            o_wb_rdt <= wb_req ? rd_data : 32'd0;
        end
    end

    assign o_irq = pending_q & ie_q;

endmodule
